// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus interface.
// Bundles the instruction-memory request/response handshake and the
// fetched-instruction handoff toward decode.
//   master : fetch unit (drives imemReq/imemAddr and instrValid/instruction/pcOut)
//   slave  : environment (memory + decode; drives imemReady/imemValid/imemData/decodeReady)
interface instruction_fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemValid;
  logic [31:0] imemData;
  logic        instrValid;
  logic [31:0] instruction;
  logic [31:0] pcOut;
  logic        decodeReady;

  modport master (
    output imemReq, imemAddr, instrValid, instruction, pcOut,
    input  imemReady, imemValid, imemData, decodeReady
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instruction, pcOut,
    output imemReady, imemValid, imemData, decodeReady
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one word-aligned fetch at a time to
// instruction memory, holds the returned word for decode until consumed,
// and supports a one-cycle redirect that discards in-flight or held work.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : instruction_fetch_if.master (memory handshake + decode handoff)
//   redirect    : one-cycle pulse, restart fetching at redirectPc
//   redirectPc  : redirect target (low two bits forced to zero)
// All outputs are registered; no input reaches an output combinationally.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_if.master        bus,
  input  logic                       redirect,
  input  logic [31:0]                redirectPc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        discard;
  logic [31:0] target;

  assign target = redirectPc & 32'hFFFF_FFFC;

  assign bus.imemReq     = imem_req;
  assign bus.imemAddr    = imem_addr;
  assign bus.instrValid  = instr_valid;
  assign bus.instruction = instruction;
  assign bus.pcOut       = pc_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instruction <= NOP;
      pc_out      <= RESET_PC;
      discard     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (redirect) begin
            pc        <= target;
            imem_addr <= target;
          end else begin
            imem_addr <= pc;
          end
        end

        REQ: begin
          if (bus.imemReady) begin
            // Accepted: if a redirect lands in the same cycle the response
            // still has to be absorbed, so mark it for dropping.
            state    <= WAIT;
            imem_req <= 1'b0;
            discard  <= redirect;
            if (redirect) pc <= target;
          end else if (redirect) begin
            pc        <= target;
            imem_addr <= target;
          end
        end

        WAIT: begin
          if (redirect && bus.imemValid) begin
            // Response and redirect coincide: drop the data, refetch now.
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= target;
            pc        <= target;
            discard   <= 1'b0;
          end else if (redirect) begin
            pc      <= target;
            discard <= 1'b1;
          end else if (bus.imemValid) begin
            if (discard) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
              discard   <= 1'b0;
            end else begin
              state       <= HOLD;
              instruction <= bus.imemData;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
            end
          end
        end

        HOLD: begin
          if (redirect) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            pc          <= target;
            imem_req    <= 1'b1;
            imem_addr   <= target;
          end else if (bus.decodeReady) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= pc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .redirect   (redirect),
    .redirectPc (redirect_pc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] addr_q[$];
  instr_t      instr_q[$];
  int          acc_count = 0;
  int          mem_lat = 1;
  int          countdown = -1;
  logic [31:0] pend_addr = 32'h0;

  // Memory contents: hand-written words for the addresses this bench visits.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0010_0093;
      32'h0000_0004: return 32'h0020_0113;
      32'h0000_0008: return 32'h0030_0193;
      32'h0000_000C: return 32'h0040_0213;
      32'h0000_0010: return 32'h0050_0293;
      32'h0000_0100: return 32'h00A0_0513;
      32'h0000_0104: return 32'h00B0_0593;
      32'h0000_0200: return 32'h0100_0613;
      32'h0000_0204: return 32'h0110_0693;
      32'hFFFF_FFFC: return 32'hFFF0_0F93;
      default:       return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_addr(input logic [31:0] a);
    addr_q.push_back(a);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] w);
    instr_t e;
    e.pc   = a;
    e.word = w;
    instr_q.push_back(e);
  endtask

  // Hold imemReady high until n more requests have been accepted.
  task automatic run_accepts(input int n);
    int target;
    target = acc_count + n;
    bus.imemReady = 1'b1;
    for (int i = 0; i < 200 && acc_count < target; i++) tick();
    bus.imemReady = 1'b0;
    checks++;
    if (acc_count < target) begin
      errors++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d", acc_count, target);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && instr_q.size() > 0; i++) tick();
    checks++;
    if (instr_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", instr_q.size());
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && bus.instrValid !== 1'b1; i++) tick();
    check32("wait_instr_valid", {31'h0, bus.instrValid}, 32'h1);
  endtask

  // Memory model: latency mem_lat cycles after acceptance; checks each
  // accepted address against the expected-address queue.
  initial begin
    bus.imemValid = 1'b0;
    bus.imemData  = 32'h0;
    forever begin
      @(negedge clk);
      bus.imemValid = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.imemValid = 1'b1;
          bus.imemData  = mem_word(pend_addr);
          countdown     = -1;
        end
      end
      if (rst_n && bus.imemReq && bus.imemReady) begin
        acc_count++;
        pend_addr = bus.imemAddr;
        countdown = mem_lat;
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got %h expected none", bus.imemAddr);
        end else begin
          check32("fetch_addr", bus.imemAddr, addr_q.pop_front());
        end
      end
    end
  end

  // Monitor: every consumed instruction must match the head of the queue.
  initial begin
    instr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.instrValid && bus.decodeReady) begin
        if (instr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h word %h expected none", bus.pcOut, bus.instruction);
        end else begin
          e = instr_q.pop_front();
          check32("pc_out", bus.pcOut, e.pc);
          check32("instruction", bus.instruction, e.word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imemReady   = 1'b0;
    bus.decodeReady = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check32("rst_imem_req",    {31'h0, bus.imemReq},    32'h0);
    check32("rst_imem_addr",   bus.imemAddr,            32'h0);
    check32("rst_instr_valid", {31'h0, bus.instrValid}, 32'h0);
    check32("rst_instruction", bus.instruction,         32'h0000_0013);
    check32("rst_pc_out",      bus.pcOut,               32'h0);
    tick();
    rst_n = 1'b1;

    // Sequential fetch 0x0, 0x4, 0x8
    push_addr(32'h0);  push_exp(32'h0, 32'h0010_0093);
    push_addr(32'h4);  push_exp(32'h4, 32'h0020_0113);
    push_addr(32'h8);  push_exp(32'h8, 32'h0030_0193);
    run_accepts(3);
    drain();

    // Memory not ready for 3 cycles: request held steady
    repeat (3) begin
      @(negedge clk);
      check32("stall_imem_req",  {31'h0, bus.imemReq}, 32'h1);
      check32("stall_imem_addr", bus.imemAddr,         32'hC);
    end
    tick();
    bus.decodeReady = 1'b0;
    push_addr(32'hC);  push_exp(32'hC, 32'h0040_0213);
    run_accepts(1);

    // Decode stalled 5 cycles in HOLD: outputs frozen, no new request
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      check32("hold_instr_valid", {31'h0, bus.instrValid}, 32'h1);
      check32("hold_instruction", bus.instruction,         32'h0040_0213);
      check32("hold_pc_out",      bus.pcOut,               32'hC);
      check32("hold_imem_req",    {31'h0, bus.imemReq},    32'h0);
    end
    tick();
    bus.decodeReady = 1'b1;
    push_addr(32'h10); push_exp(32'h10, 32'h0050_0293);
    run_accepts(1);
    drain();

    // Redirect in REQ (not accepted), misaligned target gets aligned
    redirect = 1'b1;
    redirect_pc = 32'h0000_000B;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check32("redir_req_imem_req",  {31'h0, bus.imemReq}, 32'h1);
    check32("redir_req_imem_addr", bus.imemAddr,         32'h8);
    tick();

    // Redirect while waiting on 0x8: returned word must be dropped
    mem_lat = 3;
    push_addr(32'h8);
    run_accepts(1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    mem_lat = 1;
    push_addr(32'h100); push_exp(32'h100, 32'h00A0_0513);
    run_accepts(1);
    drain();

    // Redirect coincident with returning data
    push_addr(32'h104);
    run_accepts(1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    push_addr(32'h200); push_exp(32'h200, 32'h0100_0613);
    run_accepts(1);
    drain();

    // Redirect in HOLD with decode stalled
    bus.decodeReady = 1'b0;
    push_addr(32'h204);
    run_accepts(1);
    wait_valid();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check32("redir_hold_instr_valid", {31'h0, bus.instrValid}, 32'h0);
    check32("redir_hold_imem_req",    {31'h0, bus.imemReq},    32'h1);
    check32("redir_hold_imem_addr",   bus.imemAddr,            32'hFFFF_FFFC);
    tick();
    bus.decodeReady = 1'b1;

    // Address wrap 0xFFFF_FFFC -> 0x0
    push_addr(32'hFFFF_FFFC); push_exp(32'hFFFF_FFFC, 32'hFFF0_0F93);
    push_addr(32'h0);         push_exp(32'h0,         32'h0010_0093);
    run_accepts(2);
    drain();

    // Reset pulse while in WAIT; late response after release is ignored
    mem_lat = 3;
    push_addr(32'h4);
    run_accepts(1);
    rst_n = 1'b0;
    @(negedge clk);
    check32("midrst_imem_req",    {31'h0, bus.imemReq},    32'h0);
    check32("midrst_instr_valid", {31'h0, bus.instrValid}, 32'h0);
    check32("midrst_imem_addr",   bus.imemAddr,            32'h0);
    tick();
    rst_n = 1'b1;
    mem_lat = 1;
    repeat (3) begin
      @(negedge clk);
      check32("late_valid_instr_valid", {31'h0, bus.instrValid}, 32'h0);
    end
    tick();
    push_addr(32'h0); push_exp(32'h0, 32'h0010_0093);
    run_accepts(1);
    drain();

    repeat (5) tick();
    check32("addr_queue_empty",  32'(addr_q.size()),  32'h0);
    check32("instr_queue_empty", 32'(instr_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address used after reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imemReq  output  1  fetch request to instruction memory, registered.
REQ-005 imemAddr  output  32  word-aligned fetch address, valid while imemReq=1.
REQ-006 imemReady  input  1  memory accepts request in cycles where imemReq=1 and imemReady=1.
REQ-007 imemValid  input  1  read data returned, one pulse per accepted request, no earlier than the cycle after acceptance.
REQ-008 imemData  input  32  instruction word, valid with imemValid.
REQ-009 instrValid  output  1  instruction/pc outputs valid toward decode and immediate generation.
REQ-010 instruction  output  32  registered fetched word, feeds decode and immediate generation.
REQ-011 pcOut  output  32  address of the word on instruction.
REQ-012 decodeReady  input  1  decode consumes instruction when instrValid=1 and decodeReady=1.
REQ-013 redirect  input  1  one-cycle pulse: discard in-flight or held work and fetch from redirectPc.
REQ-014 redirectPc  input  32  new target, sampled only when redirect=1.

Function
REQ-015 States IDLE, REQ, WAIT, HOLD; one request outstanding at most.
REQ-016 IDLE -> REQ on the first clock edge after reset release; imemReq asserts that cycle.
REQ-017 REQ: imemReq=1, imemAddr=pc; acceptance (imemReady=1) -> WAIT, imemReq=0 next cycle.
REQ-018 WAIT: imemValid=1 -> HOLD; instruction<=imemData, pcOut<=pc, instrValid<=1, pc<=pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 HOLD: instruction, pcOut, instrValid stable until decodeReady=1; on consumption -> REQ next cycle, instrValid<=0.
REQ-020 Minimum throughput: one instruction per 4 cycles with single-cycle memory; back-to-back overlap is not required.
REQ-021 redirectPc[1:0] SHALL be forced to 2'b00 when loaded into pc.
REQ-022 Redirect in REQ (accepted or not that cycle): pc<=redirectPc; if accepted same cycle, enter WAIT with discard flag set, else remain REQ with new address next cycle.
REQ-023 Redirect in WAIT: discard flag set; returning data dropped (instrValid stays 0), then -> REQ at redirectPc.
REQ-024 Redirect in WAIT coincident with imemValid: data dropped, -> REQ at redirectPc next cycle.
REQ-025 Redirect in HOLD: instrValid<=0 next cycle regardless of decodeReady, pc<=redirectPc, -> REQ.
REQ-026 Redirect in IDLE: pc<=redirectPc, -> REQ.
REQ-027 Redirect takes priority over every other transition in the same cycle.
REQ-028 imemValid outside WAIT SHALL be ignored.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 rst_n=0 asynchronously forces state=IDLE, pc=RESET_PC, imemReq=0, imemAddr=RESET_PC, instrValid=0, instruction=32'h0000_0013 (NOP), pcOut=RESET_PC, discard flag=0.
REQ-031 Reset asserted mid-transaction abandons it; a late imemValid after reset release SHALL be ignored (state not WAIT).

Verification
REQ-032 Reset release, imemReady=1, memory latency 1, decodeReady=1 -> fetch addresses 0x0,0x4,0x8 in order; instruction matches imemData; pcOut=0x0,0x4,0x8.
REQ-033 imemReady=0 for 3 cycles in REQ -> imemReq and imemAddr held constant all 3 cycles; single acceptance only.
REQ-034 decodeReady=0 for 5 cycles in HOLD -> instruction/pcOut/instrValid unchanged, no new imemReq; fetch at pc+4 starts after decodeReady=1.
REQ-035 redirect to 0x0000_0103 while in WAIT at address 0x8 -> returned word for 0x8 never appears on instruction; next imemAddr=0x0000_0100, pcOut=0x100.
REQ-036 pc=0xFFFF_FFFC fetched and consumed -> next imemAddr=0x0000_0000.
REQ-037 rst_n pulsed low while in WAIT, imemValid arriving one cycle after release -> instrValid stays 0; next fetch at RESET_PC.
